// File: rtl/rr_sel_arbiter_8ch.sv
// Round-robin arbiter driving the select of a downstream 8:1 channel mux.
// Registered sel/grant/valid held stable until accepted; priority rotates.
module rr_sel_arbiter_8ch #(
  parameter logic [2:0] PARK_SEL = 3'd0,
  parameter logic [2:0] INIT_PTR = 3'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [2:0] sel,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] grant,
  output logic [7:0] ack,
  output logic       accept
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] sel_q, sel_d;
  logic [7:0] grant_q, grant_d;
  logic       valid_q, valid_d;

  logic [2:0] base;
  logic [7:0] mreq;
  logic       found;
  logic [2:0] win;

  // First requester at or after base, wrapping through 7 -> 0.
  function automatic logic [3:0] pick(
    input logic [7:0] r,
    input logic [2:0] b
  );
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0;
    for (int i = 7; i >= 0; i--) begin
      idx = b + 3'(i);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign accept = valid_q & out_ready;
  assign ack    = grant_q & {8{accept}};
  assign sel       = sel_q;
  assign out_valid = valid_q;
  assign grant     = grant_q;

  always_comb begin
    base = ptr_q;
    mreq = req;
    if (state_q == GRANT) begin
      base = sel_q + 3'd1;
      mreq = req & ~grant_q;
    end
    {found, win} = pick(mreq, base);
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = GRANT;
          sel_d   = win;
          grant_d = 8'(1) << win;
          valid_d = 1'b1;
        end else begin
          sel_d   = PARK_SEL;
          grant_d = 8'h00;
          valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (accept) begin
          ptr_d = sel_q + 3'd1;
          if (found) begin
            sel_d   = win;
            grant_d = 8'(1) << win;
            valid_d = 1'b1;
          end else begin
            state_d = IDLE;
            sel_d   = PARK_SEL;
            grant_d = 8'h00;
            valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= INIT_PTR;
      sel_q   <= PARK_SEL;
      grant_q <= 8'h00;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_rr_sel_arbiter_8ch.sv
// Directed bench for rr_sel_arbiter_8ch: vector table plus
// hand sequences for rotation, stall, wrap and async reset.
module tb_rr_sel_arbiter_8ch;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [2:0] sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] grant;
  logic [7:0] ack;
  logic       accept;

  int n_cmp = 0;
  int n_bad = 0;

  rr_sel_arbiter_8ch dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant     (grant),
    .ack       (ack),
    .accept    (accept)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] req;
    logic       rdy;
    logic       v;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic [7:0] ack;
    logic       acc;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [7:0] got,
                     input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic v,
                         input logic [2:0] s, input logic [7:0] g,
                         input logic [7:0] a, input logic acc);
    chk({nm, ".valid"}, 8'(out_valid), 8'(v));
    chk({nm, ".sel"}, 8'(sel), 8'(s));
    chk({nm, ".grant"}, grant, g);
    chk({nm, ".ack"}, ack, a);
    chk({nm, ".accept"}, 8'(accept), 8'(acc));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  initial begin
    tbl[0]  = '{8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0};
    tbl[1]  = '{8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0};
    tbl[2]  = '{8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0};
    tbl[3]  = '{8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0};
    tbl[4]  = '{8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0};
    tbl[5]  = '{8'h08, 1'b1, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0};
    tbl[6]  = '{8'h00, 1'b1, 1'b1, 3'd3, 8'h08, 8'h08, 1'b1};
    tbl[7]  = '{8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0};
    tbl[8]  = '{8'h11, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0};
    tbl[9]  = '{8'h11, 1'b1, 1'b1, 3'd4, 8'h10, 8'h10, 1'b1};
    tbl[10] = '{8'h00, 1'b1, 1'b1, 3'd0, 8'h01, 8'h01, 1'b1};
    tbl[11] = '{8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0};

    do_reset();
    chk_all("reset", 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);

    for (int i = 0; i < 12; i++) begin
      req = tbl[i].req;
      out_ready = tbl[i].rdy;
      #1;
      chk_all($sformatf("vec%0d", i), tbl[i].v, tbl[i].sel,
              tbl[i].gnt, tbl[i].ack, tbl[i].acc);
      step();
    end

    // All channels requesting: one grant per clock, walking and wrapping
    do_reset();
    req = 8'hFF;
    out_ready = 1'b1;
    #1;
    chk_all("all.idle", 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    step();
    for (int k = 0; k < 10; k++) begin
      logic [2:0] s;
      s = 3'(k % 8);
      chk_all($sformatf("all%0d", k), 1'b1, s, 8'(1) << s,
              8'(1) << s, 1'b1);
      step();
    end

    // Stall: grant held while req changes underneath
    do_reset();
    req = 8'h20;
    out_ready = 1'b0;
    step();
    for (int k = 0; k < 4; k++) begin
      if (k == 1) req = 8'h24;
      #1;
      chk_all($sformatf("stall%0d", k), 1'b1, 3'd5, 8'h20,
              8'h00, 1'b0);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk_all("stall.acc", 1'b1, 3'd5, 8'h20, 8'h20, 1'b1);
    step();
    out_ready = 1'b0;
    #1;
    chk_all("stall.next", 1'b1, 3'd2, 8'h04, 8'h00, 1'b0);

    // Pointer wrap: serve ch6, then ch0 beats ch6
    do_reset();
    req = 8'h40;
    out_ready = 1'b1;
    step();
    chk_all("wrap.ch6", 1'b1, 3'd6, 8'h40, 8'h40, 1'b1);
    req = 8'h00;
    step();
    req = 8'h41;
    #1;
    chk_all("wrap.idle", 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    step();
    chk_all("wrap.ch0", 1'b1, 3'd0, 8'h01, 8'h01, 1'b1);
    step();
    chk_all("wrap.ch6b", 1'b1, 3'd6, 8'h40, 8'h40, 1'b1);

    // Async reset mid-grant
    do_reset();
    req = 8'h10;
    out_ready = 1'b0;
    step();
    chk_all("ar.pre", 1'b1, 3'd4, 8'h10, 8'h00, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_all("ar.asrt", 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk_all("ar.post", 1'b1, 3'd4, 8'h10, 8'h00, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
